rtc_bus_arbiter: RTL and testbench
==================================

Name: rtc_bus_arbiter

Overview:
Arbitrates the single RTC parallel bus (protocol engine driving ChipSelect/Read/Write/AoD) among four requesters: init (0), reset (1), write/programming (2) and permanent read (3).
Replaces the ad-hoc address/data muxing at the top level with one registered command path and a req/gnt/done handshake.
Sequences one protocol transaction at a time and supports locked bursts, so a multi-register write is not interleaved with reads.

Parameters:
LOCK_MAX, 16, max transactions in one locked burst before forced release (1..255)
TIMEOUT_CYC, 255, cycles in WAIT without proto_done before abort (only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
req  in  4  request per requester; bit 0 highest priority
lock  in  4  burst lock per requester, sampled in RESP
rw_in  in  4  1=read, 0=write, per requester
addr_in  in  32  requester i address at [8i+7:8i]
wdata_in  in  32  requester i write data at [8i+7:8i]
gnt  out  4  one-hot grant, registered
done  out  4  one-cycle completion pulse to granted requester
rdata  out  8  read data, valid while done pulses, held until next done
timeout  out  1  one-cycle pulse on aborted transaction
proto_start  out  1  one-cycle transaction start to protocol engine
proto_rw  out  1  latched rw of current transaction
proto_addr  out  8  latched address
proto_wdata  out  8  latched write data
proto_busy  in  1  protocol engine busy
proto_done  in  1  one-cycle end of transaction from protocol engine
proto_rdata  in  8  read data, valid with proto_done

Behaviour:
- Reset (synchronous): state=IDLE. gnt, done, timeout, proto_start = 0. rdata, proto_addr, proto_wdata = 8'h00. proto_rw=1. Burst and timeout counters = 0.
- Reset mid-transaction abandons the transaction silently: no done pulse. The protocol engine is reset by the same Reset.
- States: IDLE, ISSUE, WAIT, RESP, HOLD.
- IDLE:
  - If any req is set, the lowest set index wins (fixed priority 0>1>2>3).
  - At the same edge: gnt = onehot(winner); proto_rw/addr/wdata latched from the winner's slice; burst counter = 1; go to ISSUE.
  - No req: stay in IDLE, gnt = 0.
- ISSUE:
  - If proto_busy=0: proto_start=1 for exactly one cycle, then go to WAIT.
  - If proto_busy=1: wait with proto_start=0.
- WAIT:
  - On proto_done: if proto_rw=1, rdata <= proto_rdata; done[g] pulses the next cycle; go to RESP.
  - Write transactions leave rdata unchanged.
- RESP (one cycle):
  - If lock[g]=1 and burst counter < LOCK_MAX: go to HOLD with gnt held.
  - Otherwise: gnt = 0 and go to IDLE. The IDLE cycle is a mandatory bubble, so every unlocked transaction re-arbitrates.
- HOLD:
  - If req[g]=1: latch new command from slice g, increment burst counter, go to ISSUE. Higher-priority requests are ignored.
  - If req[g]=0 and lock[g]=0: gnt = 0, go to IDLE.
  - Otherwise stay in HOLD.
- Requester rules:
  - Command fields must be stable while req is high and gnt is not yet set.
  - Dropping req after gnt does not cancel the transaction; done still pulses.
  - req still high in IDLE after done counts as a new request.
- Latency: req rising in IDLE (unbusy engine) → gnt at edge +1 → proto_start high during cycle +1 → done one cycle after proto_done.
- Width: the burst counter is 8 bits and saturates at LOCK_MAX; it never wraps.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC with no proto_done: rdata <= 8'hFF, done[g] and timeout pulse together, go to RESP with the lock ignored (forced release).
  - proto_done in the same cycle as the terminal count wins: normal completion, no timeout.
- Undefined: WAIT lasts until proto_done; timeout is tied to 0.

Test Plan:
- Reset, then req=4'b1000 read addr 8'h21, engine returns 8'h45 → gnt=4'b1000 one cycle after req; one proto_start; done[3] pulse with rdata=8'h45; gnt=0 after RESP.
- req=4'b0110 simultaneously → requester 1 served first; requester 2 granted after the IDLE bubble; exactly two proto_start pulses.
- Requester 2 with lock=1, 3 back-to-back writes (addr 8'h21/22/23, data 8'h10/11/12) while req[3]=1 → three writes issued consecutively with gnt=4'b0100 held, no read in between; requester 3 served after lock drops.
- Lock held for 20 transactions with LOCK_MAX=16 → forced release after the 16th done; pending req[3] is granted.
- proto_busy=1 for 5 cycles after grant → proto_start is delayed until busy=0 and pulses exactly once.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=10, no proto_done → done and timeout pulse together, rdata=8'hFF; Reset asserted during WAIT → all outputs at reset values, no done pulse.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: fixed-priority, lock-capable arbiter for the RTC protocol engine.
// Optional feature macro ARB_TIMEOUT_EN: abort a WAIT that outlives TIMEOUT_CYC cycles.
module rtc_bus_arbiter #(
    parameter int LOCK_MAX    = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [3:0]  rw_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [7:0]  rdata,
    output logic        timeout,
    output logic        proto_start,
    output logic        proto_rw,
    output logic [7:0]  proto_addr,
    output logic [7:0]  proto_wdata,
    input  logic        proto_busy,
    input  logic        proto_done,
    input  logic [7:0]  proto_rdata
);
    // state | meaning
    // IDLE  | no grant; arbitrate among req
    // ISSUE | grant held; start engine once it is not busy
    // WAIT  | transaction in flight; wait for proto_done
    // RESP  | done pulses; release or keep a locked burst
    // HOLD  | locked burst; wait for owner's next command
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, HOLD} state_t;

    if (LOCK_MAX < 1 || LOCK_MAX > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
        $error("rtc_bus_arbiter: LOCK_MAX and TIMEOUT_CYC must be in 1..255");
    end

    localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  done_q, done_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        proto_rw_q, proto_rw_d;
    logic [7:0]  proto_addr_q, proto_addr_d;
    logic [7:0]  proto_wdata_q, proto_wdata_d;
    logic [7:0]  burst_q, burst_d;
    logic        forced_rel;

    logic [1:0]  win_idx, own_idx, cmd_idx;
    logic        own_lock, own_req;
    logic        cmd_rw;
    logic [7:0]  cmd_addr, cmd_wdata;

    function automatic logic [1:0] first_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign win_idx   = first_set(req);
    assign own_idx   = first_set(gnt_q);
    assign own_lock  = |(lock & gnt_q);
    assign own_req   = |(req & gnt_q);
    // IDLE latches the arbitration winner, HOLD latches the burst owner
    assign cmd_idx   = (state_q == IDLE) ? win_idx : own_idx;
    assign cmd_rw    = rw_in[cmd_idx];
    assign cmd_addr  = addr_in[{cmd_idx, 3'b000} +: 8];
    assign cmd_wdata = wdata_in[{cmd_idx, 3'b000} +: 8];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       timeout_q, timeout_d;
    assign forced_rel = timeout_q;
    assign timeout    = timeout_q;
`else
    assign forced_rel = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        done_d        = '0;
        rdata_d       = rdata_q;
        proto_rw_d    = proto_rw_q;
        proto_addr_d  = proto_addr_q;
        proto_wdata_d = proto_wdata_q;
        burst_d       = burst_q;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d         = 4'b0001 << win_idx;
                    proto_rw_d    = cmd_rw;
                    proto_addr_d  = cmd_addr;
                    proto_wdata_d = cmd_wdata;
                    burst_d       = 8'd1;
                    state_d       = ISSUE;
                end else begin
                    gnt_d = '0;
                end
            end
            ISSUE: begin
                if (!proto_busy) begin
                    state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (proto_done) begin
                    if (proto_rw_q) rdata_d = proto_rdata;
                    done_d  = gnt_q;
                    state_d = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    rdata_d   = 8'hFF;
                    done_d    = gnt_q;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`endif
            end
            RESP: begin
                if (own_lock && (burst_q < LOCK_LIM) && !forced_rel) begin
                    state_d = HOLD;
                end else begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (own_req) begin
                    proto_rw_d    = cmd_rw;
                    proto_addr_d  = cmd_addr;
                    proto_wdata_d = cmd_wdata;
                    burst_d       = (burst_q < LOCK_LIM) ? burst_q + 8'd1 : burst_q;
                    state_d       = ISSUE;
                end else if (!own_lock) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            done_q        <= '0;
            rdata_q       <= 8'h00;
            proto_rw_q    <= 1'b1;
            proto_addr_q  <= 8'h00;
            proto_wdata_q <= 8'h00;
            burst_q       <= 8'd0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q      <= 8'd0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            proto_rw_q    <= proto_rw_d;
            proto_addr_q  <= proto_addr_d;
            proto_wdata_q <= proto_wdata_d;
            burst_q       <= burst_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    // start is valid for the whole ISSUE cycle in which the engine is free
    assign proto_start = (state_q == ISSUE) && !proto_busy;
    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign proto_rw    = proto_rw_q;
    assign proto_addr  = proto_addr_q;
    assign proto_wdata = proto_wdata_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter with a small protocol-engine model (read data = addr ^ 8'h64).
module tb_rtc_bus_arbiter;
    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  req, lock, rw_in;
    logic [31:0] addr_in, wdata_in;
    logic [3:0]  gnt, done;
    logic [7:0]  rdata;
    logic        timeout, proto_start, proto_rw;
    logic [7:0]  proto_addr, proto_wdata;
    logic        proto_busy;
    logic        proto_done  = 1'b0;
    logic [7:0]  proto_rdata = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rtc_bus_arbiter #(.LOCK_MAX(16), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .Reset(Reset), .req(req), .lock(lock), .rw_in(rw_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt(gnt), .done(done),
        .rdata(rdata), .timeout(timeout), .proto_start(proto_start),
        .proto_rw(proto_rw), .proto_addr(proto_addr), .proto_wdata(proto_wdata),
        .proto_busy(proto_busy), .proto_done(proto_done), .proto_rdata(proto_rdata)
    );

    // protocol engine model: answers each start two cycles later
    logic       eng_respond;
    logic       eng_st, eng_r;
    logic [7:0] eng_a, eng_w, eng_pend;
    logic [3:0] eng_g;
    int         eng_cnt = 0;
    int         n_start = 0;
    logic [7:0] log_addr [64];
    logic [7:0] log_wdata[64];
    logic       log_rw   [64];
    logic [3:0] log_gnt  [64];

    always @(posedge clk) begin
        eng_st = proto_start;
        eng_a  = proto_addr;
        eng_w  = proto_wdata;
        eng_r  = proto_rw;
        eng_g  = gnt;
        #1;
        proto_done = 1'b0;
        if (Reset) begin
            eng_cnt = 0;
        end else begin
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    proto_done  = 1'b1;
                    proto_rdata = eng_pend ^ 8'h64;
                end
            end
            if (eng_st) begin
                if (n_start < 64) begin
                    log_addr[n_start]  = eng_a;
                    log_wdata[n_start] = eng_w;
                    log_rw[n_start]    = eng_r;
                    log_gnt[n_start]   = eng_g;
                end
                n_start++;
                if (eng_respond) begin
                    eng_cnt  = 2;
                    eng_pend = eng_a;
                end
            end
        end
    end

    int done_cnt[4] = '{0, 0, 0, 0};
    int n_to = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
        if (timeout) n_to++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_cmd(input int i, input logic rw, input logic [7:0] a, input logic [7:0] d);
        rw_in[i]           = rw;
        addr_in[8*i +: 8]  = a;
        wdata_in[8*i +: 8] = d;
    endtask

    task automatic wait_done(input int idx, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (done[idx]) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; req = '0; lock = '0; rw_in = '0; addr_in = '0; wdata_in = '0;
        proto_busy = 1'b0; eng_respond = 1'b1;
        tick(3);
        n_checks++;
        if ({gnt, done, timeout, proto_start} !== 10'b0)
            $display("FAIL reset_ctrl: gnt=%b done=%b timeout=%b start=%b, want all 0", gnt, done, timeout, proto_start);
        else n_pass++;
        n_checks++;
        if ({rdata, proto_addr, proto_wdata, proto_rw} !== {8'h00, 8'h00, 8'h00, 1'b1})
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h rw=%b, want 00 00 00 1", rdata, proto_addr, proto_wdata, proto_rw);
        else n_pass++;
        Reset = 1'b0;
        tick(2);
        n_checks++;
        if (gnt !== 4'b0000) $display("FAIL idle_no_req: gnt=%b want 0000", gnt);
        else n_pass++;
    endtask

    task automatic test_single_read();
        int s0;
        bit ok;
        s0 = n_start;
        set_cmd(3, 1'b1, 8'h21, 8'h00);
        req = 4'b1000;
        tick(1);
        n_checks++;
        if ({gnt, proto_start, proto_addr, proto_rw} !== {4'b1000, 1'b1, 8'h21, 1'b1})
            $display("FAIL single_grant: gnt=%b start=%b addr=%h rw=%b, want 1000 1 21 1", gnt, proto_start, proto_addr, proto_rw);
        else n_pass++;
        req = 4'b0000;
        wait_done(3, 20, ok);
        n_checks++;
        if (!ok || done !== 4'b1000 || rdata !== 8'h45)
            $display("FAIL single_done: seen=%0d done=%b rdata=%h, want 1 1000 45", ok, done, rdata);
        else n_pass++;
        tick(1);
        n_checks++;
        if ({gnt, done} !== 8'h00 || rdata !== 8'h45)
            $display("FAIL single_release: gnt=%b done=%b rdata=%h, want 0000 0000 45", gnt, done, rdata);
        else n_pass++;
        n_checks++;
        if (n_start - s0 !== 1) $display("FAIL single_starts: got %0d want 1", n_start - s0);
        else n_pass++;
    endtask

    task automatic test_priority();
        int s0;
        bit ok;
        s0 = n_start;
        set_cmd(1, 1'b1, 8'h31, 8'h00);
        set_cmd(2, 1'b0, 8'h42, 8'h77);
        req = 4'b0110;
        tick(1);
        n_checks++;
        if (gnt !== 4'b0010) $display("FAIL prio_first: gnt=%b want 0010", gnt);
        else n_pass++;
        req = 4'b0100;
        wait_done(1, 20, ok);
        n_checks++;
        if (!ok || rdata !== 8'h55) $display("FAIL prio_done1: seen=%0d rdata=%h want 1 55", ok, rdata);
        else n_pass++;
        tick(1);
        n_checks++;
        if (gnt !== 4'b0000) $display("FAIL prio_bubble: gnt=%b want 0000", gnt);
        else n_pass++;
        tick(1);
        n_checks++;
        if ({gnt, proto_rw, proto_addr, proto_wdata} !== {4'b0100, 1'b0, 8'h42, 8'h77})
            $display("FAIL prio_second: gnt=%b rw=%b addr=%h wdata=%h, want 0100 0 42 77", gnt, proto_rw, proto_addr, proto_wdata);
        else n_pass++;
        req = 4'b0000;
        wait_done(2, 20, ok);
        n_checks++;
        if (!ok || rdata !== 8'h55) $display("FAIL prio_write_keeps_rdata: seen=%0d rdata=%h want 1 55", ok, rdata);
        else n_pass++;
        tick(1);
        n_checks++;
        if (n_start - s0 !== 2 || log_gnt[s0] !== 4'b0010 || log_gnt[s0+1] !== 4'b0100)
            $display("FAIL prio_order: starts=%0d gnt0=%b gnt1=%b, want 2 0010 0100", n_start - s0, log_gnt[s0], log_gnt[s0+1]);
        else n_pass++;
    endtask

    task automatic test_lock_burst();
        int s0;
        bit ok;
        s0 = n_start;
        set_cmd(2, 1'b0, 8'h21, 8'h10);
        set_cmd(3, 1'b1, 8'h30, 8'h00);
        lock = 4'b0100;
        req  = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            wait_done(2, 20, ok);
            n_checks++;
            if (!ok || gnt !== 4'b0100) $display("FAIL burst_done%0d: seen=%0d gnt=%b want 1 0100", k, ok, gnt);
            else n_pass++;
            if (k < 2) set_cmd(2, 1'b0, 8'(8'h22 + k), 8'(8'h11 + k));
            else begin
                lock = 4'b0000;
                req  = 4'b1000;
            end
        end
        wait_done(3, 20, ok);
        n_checks++;
        if (!ok || rdata !== 8'h54) $display("FAIL burst_after: seen=%0d rdata=%h want 1 54", ok, rdata);
        else n_pass++;
        req = 4'b0000;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({log_gnt[s0+k], log_rw[s0+k], log_addr[s0+k], log_wdata[s0+k]} !== {4'b0100, 1'b0, 8'(8'h21 + k), 8'(8'h10 + k)})
                $display("FAIL burst_txn%0d: gnt=%b rw=%b addr=%h wdata=%h, want 0100 0 %h %h", k,
                         log_gnt[s0+k], log_rw[s0+k], log_addr[s0+k], log_wdata[s0+k], 8'(8'h21 + k), 8'(8'h10 + k));
            else n_pass++;
        end
        n_checks++;
        if (n_start - s0 !== 4 || log_gnt[s0+3] !== 4'b1000 || log_addr[s0+3] !== 8'h30)
            $display("FAIL burst_read_last: starts=%0d gnt=%b addr=%h, want 4 1000 30", n_start - s0, log_gnt[s0+3], log_addr[s0+3]);
        else n_pass++;
    endtask

    task automatic test_lock_max();
        bit ok;
        int n_ok, n_hold;
        n_ok = 0;
        n_hold = 0;
        set_cmd(2, 1'b0, 8'h50, 8'hA5);
        set_cmd(3, 1'b1, 8'h60, 8'h00);
        lock = 4'b0100;
        req  = 4'b1100;
        for (int k = 1; k <= 16; k++) begin
            wait_done(2, 20, ok);
            if (ok) n_ok++;
            if (k < 16) begin
                tick(1);
                if (gnt === 4'b0100) n_hold++;
            end
        end
        n_checks++;
        if (n_ok !== 16 || n_hold !== 15) $display("FAIL lockmax_burst: dones=%0d held=%0d want 16 15", n_ok, n_hold);
        else n_pass++;
        tick(1);
        n_checks++;
        if (gnt !== 4'b0000) $display("FAIL lockmax_release: gnt=%b want 0000", gnt);
        else n_pass++;
        req = 4'b1000;
        tick(1);
        n_checks++;
        if (gnt !== 4'b1000) $display("FAIL lockmax_next: gnt=%b want 1000", gnt);
        else n_pass++;
        wait_done(3, 20, ok);
        req  = 4'b0000;
        lock = 4'b0000;
        n_checks++;
        if (!ok || rdata !== 8'h04) $display("FAIL lockmax_read: seen=%0d rdata=%h want 1 04", ok, rdata);
        else n_pass++;
        tick(1);
    endtask

    task automatic test_busy();
        int s0;
        bit ok, started;
        s0 = n_start;
        started = 1'b0;
        set_cmd(1, 1'b1, 8'h11, 8'h00);
        proto_busy = 1'b1;
        req = 4'b0010;
        tick(1);
        n_checks++;
        if (gnt !== 4'b0010 || proto_start !== 1'b0) $display("FAIL busy_grant: gnt=%b start=%b want 0010 0", gnt, proto_start);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (proto_start !== 1'b0) started = 1'b1;
        end
        n_checks++;
        if (started !== 1'b0) $display("FAIL busy_hold: start seen=%b want 0", started);
        else n_pass++;
        proto_busy = 1'b0;
        #1;
        n_checks++;
        if (proto_start !== 1'b1) $display("FAIL busy_release: start=%b want 1", proto_start);
        else n_pass++;
        req = 4'b0000;
        tick(1);
        n_checks++;
        if (proto_start !== 1'b0) $display("FAIL busy_single_pulse: start=%b want 0", proto_start);
        else n_pass++;
        wait_done(1, 20, ok);
        n_checks++;
        if (!ok || rdata !== 8'h75) $display("FAIL busy_done: seen=%0d rdata=%h want 1 75", ok, rdata);
        else n_pass++;
        tick(1);
        n_checks++;
        if (n_start - s0 !== 1) $display("FAIL busy_starts: got %0d want 1", n_start - s0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt[0];
        eng_respond = 1'b0;
        set_cmd(0, 1'b1, 8'h0F, 8'h3C);
        req = 4'b0001;
        tick(1);
        n_checks++;
        if (gnt !== 4'b0001) $display("FAIL rstmid_grant: gnt=%b want 0001", gnt);
        else n_pass++;
        req = 4'b0000;
        tick(3);
        Reset = 1'b1;
        tick(1);
        n_checks++;
        if ({gnt, done, timeout, proto_start} !== 10'b0 || {rdata, proto_addr, proto_wdata, proto_rw} !== {8'h00, 8'h00, 8'h00, 1'b1})
            $display("FAIL rstmid_values: gnt=%b done=%b to=%b start=%b rdata=%h addr=%h wdata=%h rw=%b", gnt, done, timeout,
                     proto_start, rdata, proto_addr, proto_wdata, proto_rw);
        else n_pass++;
        tick(1);
        Reset = 1'b0;
        eng_respond = 1'b1;
        tick(5);
        n_checks++;
        if (done_cnt[0] !== d0 || gnt !== 4'b0000) $display("FAIL rstmid_no_done: dones=%0d gnt=%b want %0d 0000", done_cnt[0], gnt, d0);
        else n_pass++;
    endtask

    task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
        int t0, n;
        bit ok;
        t0 = n_to;
        n = 0;
        ok = 1'b0;
        eng_respond = 1'b0;
        set_cmd(3, 1'b1, 8'h21, 8'h00);
        lock = 4'b1000;
        req  = 4'b1000;
        tick(1);
        n_checks++;
        if (gnt !== 4'b1000 || proto_start !== 1'b1) $display("FAIL to_grant: gnt=%b start=%b want 1000 1", gnt, proto_start);
        else n_pass++;
        req = 4'b0000;
        while (n < 40 && !ok) begin
            tick(1);
            n++;
            if (done[3]) ok = 1'b1;
        end
        n_checks++;
        if (!ok || n !== 11 || timeout !== 1'b1 || rdata !== 8'hFF)
            $display("FAIL to_abort: seen=%0d cycles=%0d timeout=%b rdata=%h, want 1 11 1 ff", ok, n, timeout, rdata);
        else n_pass++;
        tick(1);
        n_checks++;
        if ({gnt, done, timeout} !== 9'b0) $display("FAIL to_forced_release: gnt=%b done=%b to=%b want all 0", gnt, done, timeout);
        else n_pass++;
        lock = 4'b0000;
        eng_respond = 1'b1;
        n_checks++;
        if (n_to - t0 !== 1) $display("FAIL to_count: got %0d want 1", n_to - t0);
        else n_pass++;
`else
        n_checks++;
        if (n_to !== 0) $display("FAIL to_disabled: timeout pulses=%0d want 0", n_to);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_lock_burst();
        test_lock_max();
        test_busy();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
